// File: rtl/sw_systolic_array.sv
// sw_systolic_array
// Linear systolic array scoring one query against a streamed reference with
// Smith-Waterman local alignment (linear gap). PE j holds query base j;
// reference tokens walk the chain one PE per cycle, and bubbles (ref_valid low)
// travel as invalid tokens so scores do not depend on stall pattern.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin a job (only honoured in IDLE)
//   query, q_len         query bases (base j at [2j+1:2j]) and valid length
//   ref_len              reference length, 0..MAX_LEN
//   ref_base, ref_valid  streamed reference base and its valid
//   ref_ready            array takes a base this cycle
//   busy, done           job in progress / one-cycle completion pulse
//   best_score/i/j       best cell score and coordinates, held until next start
//
// Optional build macro SW_TRACE_EN adds trace_valid, trace_dir and trace_i,
// exposing each PE's per-token decision for external traceback storage.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD   | latch job config, clear PE scores and max tracker
// S_STREAM | ref_ready high, accepting ref_len bases
// S_DRAIN  | last token walking the chain, max tracker settling
// S_DONE   | done pulse, results valid

module sw_systolic_array #(
   parameter int NUM_PE   = 4,
   parameter int SCORE_W  = 8,
   parameter int MAX_LEN  = 64,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP      = 1,
   localparam int QLW = $clog2(NUM_PE + 1),
   localparam int RLW = $clog2(MAX_LEN + 1),
   localparam int IW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int JW  = $clog2(NUM_PE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2*NUM_PE-1:0] query,
   input  logic [QLW-1:0]      q_len,
   input  logic [RLW-1:0]      ref_len,
   input  logic [1:0]          ref_base,
   input  logic                ref_valid,
   output logic                ref_ready,
   output logic                busy,
   output logic                done,
   output logic [SCORE_W-1:0]  best_score,
   output logic [IW-1:0]       best_i,
   output logic [JW-1:0]       best_j
`ifdef SW_TRACE_EN
   ,
   output logic [NUM_PE-1:0]    trace_valid,
   output logic [2*NUM_PE-1:0]  trace_dir,
   output logic [IW*NUM_PE-1:0] trace_i
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int SW = SCORE_W + 2;
   localparam logic signed [SW-1:0] S_MATCH = SW'(MATCH);
   localparam logic signed [SW-1:0] S_MIS   = SW'(MISMATCH);
   localparam logic signed [SW-1:0] S_GAP   = SW'(GAP);
   localparam logic signed [SW-1:0] S_MAX   = SW'((1 << SCORE_W) - 1);

   logic [2:0]          state_q;
   logic [2*NUM_PE-1:0] query_q;
   logic [QLW-1:0]      q_len_q;
   logic [RLW-1:0]      ref_len_q;
   logic [IW-1:0]       idx_q;
   logic [QLW-1:0]      drain_q;
   logic                accept;
   logic                last_acc;

   // token leaving PE j (i.e. processed by PE j at the last edge)
   logic               tv_q [NUM_PE];
   logic [IW-1:0]      ti_q [NUM_PE];
   logic [1:0]         tb_q [NUM_PE-1];
   logic [SCORE_W-1:0] h_q    [NUM_PE];
   logic [SCORE_W-1:0] diag_q [NUM_PE];

   logic               in_v [NUM_PE];
   logic [1:0]         in_b [NUM_PE];
   logic [IW-1:0]      in_i [NUM_PE];
   logic [SCORE_W-1:0] d_in [NUM_PE];
   logic [SCORE_W-1:0] l_in [NUM_PE];
   logic [SCORE_W-1:0] h_nx [NUM_PE];
   logic [1:0]         dir_nx [NUM_PE];
   logic signed [SW-1:0] sc, cd, cu, cl, cbest;

   logic [SCORE_W-1:0] m_s;
   logic [IW-1:0]      m_i;
   logic [JW-1:0]      m_j;

   assign accept    = ref_valid && (state_q == S_STREAM);
   assign last_acc  = (RLW'(idx_q) + RLW'(1)) == ref_len_q;
   assign ref_ready = (state_q == S_STREAM);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         query_q   <= '0;
         q_len_q   <= '0;
         ref_len_q <= '0;
         idx_q     <= '0;
         drain_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) state_q <= S_LOAD;
            S_LOAD: begin
               query_q   <= query;
               q_len_q   <= q_len;
               ref_len_q <= ref_len;
               idx_q     <= '0;
               state_q   <= (ref_len == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: if (accept) begin
               idx_q <= idx_q + 1'b1;
               if (last_acc) begin
                  state_q <= S_DRAIN;
                  // last token reaches the final PE after NUM_PE-1 edges, the
                  // tracker needs one more, then one cycle to leave DRAIN
                  drain_q <= QLW'(NUM_PE);
               end
            end
            S_DRAIN: begin
               if (drain_q == '0) state_q <= S_DONE;
               else               drain_q <= drain_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // PE inputs: PE0 sees the stream directly with zero left/diag neighbours
   always_comb begin
      in_v[0] = accept;
      in_b[0] = ref_base;
      in_i[0] = idx_q;
      d_in[0] = '0;
      l_in[0] = '0;
      for (int j = 1; j < NUM_PE; j++) begin
         in_v[j] = tv_q[j-1];
         in_b[j] = tb_q[j-1];
         in_i[j] = ti_q[j-1];
         d_in[j] = diag_q[j-1];
         l_in[j] = h_q[j-1];
      end
   end

   // Cell update; ties resolve diag > up > left > zero by testing the
   // lowest-priority term first with >=.
   always_comb begin
      sc = '0; cd = '0; cu = '0; cl = '0; cbest = '0;
      for (int j = 0; j < NUM_PE; j++) begin
         sc = (in_b[j] == query_q[2*j +: 2]) ? S_MATCH : -S_MIS;
         cd = $signed({2'b00, d_in[j]}) + sc;
         cu = $signed({2'b00, h_q[j]}) - S_GAP;
         cl = $signed({2'b00, l_in[j]}) - S_GAP;
         cbest     = '0;
         dir_nx[j] = 2'b00;
         if (cl >= cbest) begin cbest = cl; dir_nx[j] = 2'b11; end
         if (cu >= cbest) begin cbest = cu; dir_nx[j] = 2'b10; end
         if (cd >= cbest) begin cbest = cd; dir_nx[j] = 2'b01; end
         h_nx[j] = (cbest > S_MAX) ? S_MAX[SCORE_W-1:0] : cbest[SCORE_W-1:0];
      end
   end

`ifdef SW_TRACE_EN
   logic [1:0] dir_q [NUM_PE];
`endif

   always_ff @(posedge clk) begin
      if (reset || state_q == S_LOAD) begin
         for (int j = 0; j < NUM_PE; j++) begin
            tv_q[j]   <= 1'b0;
            ti_q[j]   <= '0;
            h_q[j]    <= '0;
            diag_q[j] <= '0;
`ifdef SW_TRACE_EN
            dir_q[j]  <= 2'b00;
`endif
         end
         for (int j = 0; j < NUM_PE - 1; j++) tb_q[j] <= 2'b00;
      end else begin
         for (int j = 0; j < NUM_PE; j++) begin
            tv_q[j] <= in_v[j];
            ti_q[j] <= in_i[j];
            if (in_v[j]) begin
               diag_q[j] <= h_q[j];
               h_q[j]    <= h_nx[j];
`ifdef SW_TRACE_EN
               dir_q[j]  <= dir_nx[j];
`endif
            end
         end
         for (int j = 0; j < NUM_PE - 1; j++) tb_q[j] <= in_b[j];
      end
   end

`ifdef SW_TRACE_EN
   always_comb begin
      trace_valid = '0;
      trace_dir   = '0;
      trace_i     = '0;
      for (int j = 0; j < NUM_PE; j++) begin
         trace_valid[j]         = tv_q[j];
         trace_dir[2*j +: 2]    = dir_q[j];
         trace_i[IW*j +: IW]    = ti_q[j];
      end
   end
`endif

   // Scan in ascending j with strict compare: earlier cycle, then lower j wins
   always_comb begin
      m_s = best_score;
      m_i = best_i;
      m_j = best_j;
      for (int j = 0; j < NUM_PE; j++) begin
         if (tv_q[j] && (QLW'(j) < q_len_q) && (h_q[j] > m_s)) begin
            m_s = h_q[j];
            m_i = ti_q[j];
            m_j = JW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state_q == S_LOAD) begin
         best_score <= '0;
         best_i     <= '0;
         best_j     <= '0;
      end else begin
         best_score <= m_s;
         best_i     <= m_i;
         best_j     <= m_j;
      end
   end

endmodule
